// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO width/threshold defaults and depth helper
package fifo_pkg;
  localparam int FIFO_DATA_W = 10;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_AF_THR = 6;
  localparam int FIFO_AE_THR = 2;
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port array, write port (we/waddr/wdata) and registered read port (re/raddr/rdata), old data on same-address collision
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (!reset_L) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sync FIFO controller; push/data_in in, pop/data_out/valid_out out, registered count and full/empty/almost/err flags
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int AF_THR = FIFO_AF_THR,
  parameter int AE_THR = FIFO_AE_THR
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic              underflow_err
);
  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(fifo_depth(ADDR_W));
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_THR);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_THR);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count_nxt;
  logic pop_ok, push_ok;
  always_comb begin
    pop_ok = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    count_nxt = (push_ok & ~pop_ok) ? count + (ADDR_W+1)'(1) :
                (pop_ok & ~push_ok) ? count - (ADDR_W+1)'(1) : count;
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid_out <= 1'b0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
      empty <= 1'b1;
      almost_empty <= 1'b1;
      full <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count <= count_nxt;
      valid_out <= pop_ok;
      overflow_err <= push & ~push_ok;
      underflow_err <= pop & ~pop_ok;
      empty <= count_nxt == '0;
      almost_empty <= count_nxt <= AE_C;
      full <= count_nxt == FULL_C;
      almost_full <= count_nxt >= AF_C;
    end
  end
  fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .reset_L(reset_L),
    .we(push_ok),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re(pop_ok),
    .raddr(rd_ptr),
    .rdata(data_out)
  );
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic valid_out, full, empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic [3:0] count;
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] q[$];
  logic [9:0] exp_q[$];
  logic [9:0] last_d = '0;
  always #5 clk = ~clk;
  fifo_ctrl dut (
    .clk(clk),
    .reset_L(reset_L),
    .push(push),
    .data_in(data_in),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit rn, input bit p, input logic [9:0] d, input bit po);
    bit pop_ok, push_ok, eovf, eunf;
    reset_L = rn;
    push = p;
    data_in = d;
    pop = po;
    pop_ok = rn && po && q.size() > 0;
    push_ok = rn && p && (q.size() < 8 || pop_ok);
    eovf = rn && p && !push_ok;
    eunf = rn && po && !pop_ok;
    if (!rn) begin
      q.delete();
      exp_q.delete();
      last_d = '0;
    end
    if (pop_ok) exp_q.push_back(q.pop_front());
    if (push_ok) q.push_back(d);
    @(posedge clk);
    #1;
    chk("valid", 16'(valid_out), 16'(pop_ok));
    if (valid_out) begin
      if (exp_q.size() == 0) chk("spurious_valid", 16'(valid_out), 16'd0);
      else begin
        last_d = exp_q.pop_front();
        chk("data", 16'(data_out), 16'(last_d));
      end
    end else chk("hold", 16'(data_out), 16'(last_d));
    chk("count", 16'(count), 16'(q.size()));
    chk("empty", 16'(empty), 16'(q.size() == 0));
    chk("full", 16'(full), 16'(q.size() == 8));
    chk("almost_full", 16'(almost_full), 16'(q.size() >= 6));
    chk("almost_empty", 16'(almost_empty), 16'(q.size() <= 2));
    chk("overflow", 16'(overflow_err), 16'(eovf));
    chk("underflow", 16'(underflow_err), 16'(eunf));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(0, 1, 10'h3C0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, 10'(i), 0);
    step(1, 1, 10'h3FF, 0);
    for (int i = 0; i < 8; i++) step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 10'(10'h10 + i), 0);
    step(1, 1, 10'h2AA, 1);
    for (int i = 0; i < 8; i++) step(1, 0, '0, 1);
    step(1, 1, 10'h155, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 10'(10'h40 + i), q.size() >= 3);
    for (int i = 0; i < 8 && q.size() > 0; i++) step(1, 0, '0, 1);
    for (int i = 0; i < 6; i++) step(1, i < 4, 10'(10'h80 + i), i == 3);
    for (int i = 0; i < 8 && q.size() < 4; i++) step(1, 1, 10'(10'h90 + i), 0);
    chk("pre_reset_count", 16'(count), 16'd4);
    step(0, 0, '0, 1);
    step(1, 1, 10'h0AB, 0);
    step(1, 1, 10'h0CD, 0);
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 40; i++) step(1, 1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
